fetch_prefetch_buffer: RTL and testbench

Instruction prefetch unit that sits directly upstream of the pipeline's IF/ID register.
- Keeps a small in-order queue of fetched instruction words, each with its next-PC value, so the IF stage pops a ready {IR, NPC} pair instead of reading memory itself.
- Handles taken-branch redirects from the EX/MEM stage: flushes the queue and discards stale memory responses.
- Stops issuing new fetches when the core signals halt.

---
 rtl/fetch_prefetch_buffer_pkg.sv | 19 +
 rtl/fetch_prefetch_buffer_if.sv | 32 +++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_prefetch_buffer.sv | 110 +++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_prefetch_buffer_pkg.sv
// rtl/fetch_prefetch_buffer_pkg.sv - shared constants and types for the fetch prefetch buffer
// Widths, reset defaults, branch/halt opcodes for decode, and the fetch control states.
package fetch_prefetch_buffer_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam int DEFAULT_DEPTH = 4;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] DEFAULT_RESET_PC = 32'h0;

  localparam logic [5:0] OP_BEQZ = 6'h04;
  localparam logic [5:0] OP_BNEQZ = 6'h05;
  localparam logic [5:0] OP_HLT = 6'h3F;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    HALTED = 2'd1
  } state_e;

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// rtl/fetch_prefetch_buffer_if.sv - memory, IF-stage and redirect signals of the prefetch buffer
// master is the prefetch buffer's view; slave is the surrounding core/memory view.
interface fetch_prefetch_buffer_if
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [WORD_W-1:0] imem_rdata;
  logic              if_valid;
  logic [WORD_W-1:0] if_ir;
  logic [WORD_W-1:0] if_npc;
  logic              if_ready;
  logic              br_taken;
  logic [WORD_W-1:0] br_target;
  logic              halt;

  modport master (
    output imem_req, imem_addr, if_valid, if_ir, if_npc,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready, br_taken, br_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_ir, if_npc,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready, br_taken, br_target, halt
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and a head word read straight from storage
// Head reads as zero while empty so the downstream outputs are clean after reset or flush.
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [W-1:0]           pdata_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [W-1:0]           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= pdata_i;
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// rtl/fetch_prefetch_buffer.sv - instruction prefetch queue feeding the IF/ID register
// Issues in-order word fetches, queues {IR, NPC} pairs, flushes on redirect and stops on halt.
module fetch_prefetch_buffer
  import fetch_prefetch_buffer_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter logic [WORD_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic                     clk1,
  input logic                     rst_n,
  fetch_prefetch_buffer_if.master bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   pc_q, pc_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic [CW-1:0]       drop_q, drop_d;

  logic [CW-1:0]       q_count;
  logic [CW-1:0]       tag_count;
  logic [CW:0]         inflight;
  logic [2*WORD_W-1:0] q_head;
  logic [WORD_W-1:0]   tag_head;
  logic                halted, redirect, transfer, resp_keep, q_pop;

  assign halted   = (state_q == HALTED);
  assign redirect = bus.br_taken & ~halted;
  assign inflight = {1'b0, q_count} + {1'b0, outst_q};

  // Reserving queue space per outstanding request guarantees every response has a slot.
  assign bus.imem_req  = rst_n & ~halted & ~bus.br_taken & (inflight < (CW+1)'(DEPTH));
  assign bus.imem_addr = pc_q[ADDR_W-1:0];
  assign transfer      = bus.imem_req & bus.imem_gnt;

  assign resp_keep = bus.imem_rvalid & (drop_q == '0) & ~redirect;
  assign q_pop     = bus.if_valid & bus.if_ready & ~redirect;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q + CW'(transfer) - CW'(bus.imem_rvalid);
    drop_d  = drop_q;
    case (state_q)
      RUN: begin
        if (bus.halt) state_d = HALTED;
        if (redirect) begin
          pc_d = bus.br_target;
          // Everything still in flight was fetched down the abandoned path.
          drop_d = outst_q - CW'(bus.imem_rvalid);
        end else begin
          if (transfer) pc_d = pc_q + 32'd1;
          if (bus.imem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
        end
      end
      HALTED: begin
        if (bus.imem_rvalid && drop_q != '0) drop_d = drop_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.W(2*WORD_W), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk1),
    .rst_n   (rst_n),
    .push_i  (resp_keep),
    .pdata_i ({bus.imem_rdata, tag_head}),
    .pop_i   (q_pop),
    .flush_i (redirect),
    .head_o  (q_head),
    .count_o (q_count)
  );

  // Tags track every issued request, stale or not, so they stay aligned with responses.
  fetch_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_tag_q (
    .clk     (clk1),
    .rst_n   (rst_n),
    .push_i  (transfer),
    .pdata_i (pc_q + 32'd1),
    .pop_i   (bus.imem_rvalid),
    .flush_i (1'b0),
    .head_o  (tag_head),
    .count_o (tag_count)
  );

  assign bus.if_valid = (q_count != '0);
  assign bus.if_ir    = q_head[2*WORD_W-1:WORD_W];
  assign bus.if_npc   = q_head[WORD_W-1:0];

  a_inflight: assert property (@(posedge clk1) disable iff (!rst_n) inflight <= (CW+1)'(DEPTH));
  a_drop:     assert property (@(posedge clk1) disable iff (!rst_n) drop_q <= outst_q);
  a_tags:     assert property (@(posedge clk1) disable iff (!rst_n) tag_count == outst_q);

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// tb/tb_fetch_prefetch_buffer.sv - directed self-checking bench for fetch_prefetch_buffer
// Memory holds 32'hCAFE0000 + address; inputs change on negedge, outputs are checked 2 units later.
module tb_fetch_prefetch_buffer;

  logic clk1;
  logic rst_n;
  fetch_prefetch_buffer_if bus ();

  fetch_prefetch_buffer dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rel = 0;
  int lat = 1;

  logic [31:0] mem [1024];
  logic [9:0]  pend_addr[$];
  int          pend_due[$];
  logic [9:0]  req_addr[$];
  int          req_cyc[$];
  logic [31:0] dl_ir[$];
  logic [31:0] dl_npc[$];
  int          dl_cyc[$];

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // cyc labels the upcoming posedge; requests and pops are logged against that label.
  always @(negedge clk1) begin
    #1;
    cyc++;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (!rst_n) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem[pend_addr[0]];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (bus.imem_req && bus.imem_gnt) begin
        pend_addr.push_back(bus.imem_addr);
        pend_due.push_back(cyc + lat);
        req_addr.push_back(bus.imem_addr);
        req_cyc.push_back(cyc);
      end
      if (bus.if_valid && bus.if_ready && !bus.br_taken) begin
        dl_ir.push_back(bus.if_ir);
        dl_npc.push_back(bus.if_npc);
        dl_cyc.push_back(cyc);
      end
    end
  end

  task automatic do_reset(input int l);
    @(negedge clk1);
    rst_n = 1'b0;
    bus.if_ready = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.halt = 1'b0;
    bus.imem_gnt = 1'b1;
    lat = l;
    @(negedge clk1);
    rst_n = 1'b1;
    req_addr.delete(); req_cyc.delete();
    dl_ir.delete(); dl_npc.delete(); dl_cyc.delete();
    #2 rel = cyc;
  endtask

  task automatic test_reset();
    @(negedge clk1);
    #2;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", bus.imem_req); end
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", bus.if_valid); end
    n_checks++; if (bus.if_ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0", bus.if_ir); end
    n_checks++; if (bus.if_npc !== 32'h0) begin n_fail++; $display("FAIL reset_npc: got %h want 0", bus.if_npc); end
    n_checks++; if (bus.imem_addr !== 10'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
  endtask

  task automatic test_stream();
    do_reset(1);
    bus.if_ready = 1'b1;
    repeat (8) @(negedge clk1);
    #2;
    n_checks++; if (req_cyc[0] !== rel) begin n_fail++; $display("FAIL stream_first_req_cyc: got %0d want %0d", req_cyc[0], rel); end
    n_checks++; if (req_cyc[3] !== rel + 3) begin n_fail++; $display("FAIL stream_req3_cyc: got %0d want %0d", req_cyc[3], rel + 3); end
    n_checks++; if (dl_cyc[0] !== rel + 2) begin n_fail++; $display("FAIL stream_first_dl_cyc: got %0d want %0d", dl_cyc[0], rel + 2); end
    n_checks++; if (dl_cyc[3] !== rel + 5) begin n_fail++; $display("FAIL stream_dl3_cyc: got %0d want %0d", dl_cyc[3], rel + 5); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (req_addr[i] !== 10'(i)) begin n_fail++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, req_addr[i], i); end
      n_checks++; if (dl_ir[i] !== 32'hCAFE_0000 + 32'(i)) begin n_fail++; $display("FAIL stream_ir[%0d]: got %h want %h", i, dl_ir[i], 32'hCAFE_0000 + 32'(i)); end
      n_checks++; if (dl_npc[i] !== 32'(i + 1)) begin n_fail++; $display("FAIL stream_npc[%0d]: got %h want %h", i, dl_npc[i], i + 1); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(1);
    repeat (8) @(negedge clk1);
    #2;
    n_checks++; if (req_addr.size() !== 4) begin n_fail++; $display("FAIL bp_req_count: got %0d want 4", req_addr.size()); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled: got %0b want 0", bus.imem_req); end
    n_checks++; if (bus.if_ir !== 32'hCAFE_0000) begin n_fail++; $display("FAIL bp_head_ir: got %h want cafe0000", bus.if_ir); end
    n_checks++; if (bus.if_npc !== 32'h1) begin n_fail++; $display("FAIL bp_head_npc: got %h want 1", bus.if_npc); end
    @(negedge clk1);
    bus.if_ready = 1'b1;
    @(negedge clk1);
    bus.if_ready = 1'b0;
    #2;
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL bp_req_after_pop: got %0b want 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 10'd4) begin n_fail++; $display("FAIL bp_addr_after_pop: got %h want 4", bus.imem_addr); end
    repeat (5) @(negedge clk1);
    #2;
    n_checks++; if (req_addr.size() !== 5) begin n_fail++; $display("FAIL bp_req_count2: got %0d want 5", req_addr.size()); end
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled2: got %0b want 0", bus.imem_req); end
    n_checks++; if (dl_ir.size() !== 1) begin n_fail++; $display("FAIL bp_dl_count: got %0d want 1", dl_ir.size()); end
    n_checks++; if (bus.if_ir !== 32'hCAFE_0001) begin n_fail++; $display("FAIL bp_next_head: got %h want cafe0001", bus.if_ir); end
  endtask

  task automatic test_redirect();
    do_reset(3);
    bus.if_ready = 1'b1;
    repeat (2) @(negedge clk1);
    bus.br_taken = 1'b1;
    bus.br_target = 32'd40;
    #2;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL redir_no_req: got %0b want 0", bus.imem_req); end
    @(negedge clk1);
    bus.br_taken = 1'b0;
    #2;
    n_checks++; if (bus.imem_addr !== 10'd40) begin n_fail++; $display("FAIL redir_target_addr: got %0d want 40", bus.imem_addr); end
    repeat (5) @(negedge clk1);
    #2;
    n_checks++; if (req_addr[2] !== 10'd40) begin n_fail++; $display("FAIL redir_req2: got %0d want 40", req_addr[2]); end
    n_checks++; if (dl_ir[0] !== 32'hCAFE_0028) begin n_fail++; $display("FAIL redir_first_ir: got %h want cafe0028", dl_ir[0]); end
    n_checks++; if (dl_npc[0] !== 32'd41) begin n_fail++; $display("FAIL redir_first_npc: got %0d want 41", dl_npc[0]); end
    n_checks++; if (dl_cyc[0] !== rel + 7) begin n_fail++; $display("FAIL redir_first_cyc: got %0d want %0d", dl_cyc[0], rel + 7); end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(1);
    bus.if_ready = 1'b1;
    repeat (3) @(negedge clk1);
    bus.br_taken = 1'b1;
    bus.br_target = 32'd100;
    #2;
    n_checks++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL same_pre_valid: got %0b want 1", bus.if_valid); end
    @(negedge clk1);
    bus.br_taken = 1'b0;
    #2;
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL same_flushed: got %0b want 0", bus.if_valid); end
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL same_req: got %0b want 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 10'd100) begin n_fail++; $display("FAIL same_addr: got %0d want 100", bus.imem_addr); end
    repeat (4) @(negedge clk1);
    #2;
    n_checks++; if (dl_ir[0] !== 32'hCAFE_0000) begin n_fail++; $display("FAIL same_dl0: got %h want cafe0000", dl_ir[0]); end
    n_checks++; if (dl_ir[1] !== 32'hCAFE_0064) begin n_fail++; $display("FAIL same_dl1_ir: got %h want cafe0064", dl_ir[1]); end
    n_checks++; if (dl_npc[1] !== 32'd101) begin n_fail++; $display("FAIL same_dl1_npc: got %0d want 101", dl_npc[1]); end
  endtask

  task automatic test_halt();
    do_reset(3);
    repeat (3) @(negedge clk1);
    bus.halt = 1'b1;
    bus.imem_gnt = 1'b0;
    @(negedge clk1);
    bus.halt = 1'b0;
    bus.imem_gnt = 1'b1;
    #2;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_no_req: got %0b want 0", bus.imem_req); end
    repeat (2) @(negedge clk1);
    bus.if_ready = 1'b1;
    repeat (3) @(negedge clk1);
    #2;
    n_checks++; if (dl_ir.size() !== 3) begin n_fail++; $display("FAIL halt_dl_count: got %0d want 3", dl_ir.size()); end
    n_checks++; if (dl_ir[2] !== 32'hCAFE_0002) begin n_fail++; $display("FAIL halt_dl2_ir: got %h want cafe0002", dl_ir[2]); end
    n_checks++; if (dl_npc[2] !== 32'd3) begin n_fail++; $display("FAIL halt_dl2_npc: got %0d want 3", dl_npc[2]); end
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL halt_drained: got %0b want 0", bus.if_valid); end
    @(negedge clk1);
    bus.br_taken = 1'b1;
    bus.br_target = 32'd200;
    @(negedge clk1);
    bus.br_taken = 1'b0;
    repeat (3) @(negedge clk1);
    #2;
    n_checks++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_br_ignored_req: got %0b want 0", bus.imem_req); end
    n_checks++; if (req_addr.size() !== 3) begin n_fail++; $display("FAIL halt_req_count: got %0d want 3", req_addr.size()); end
    n_checks++; if (bus.imem_addr !== 10'd3) begin n_fail++; $display("FAIL halt_pc_kept: got %0d want 3", bus.imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    repeat (4) @(negedge clk1);
    #2;
    n_checks++; if (bus.if_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %0b want 1", bus.if_valid); end
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    #2;
    n_checks++; if (bus.if_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %0b want 0", bus.if_valid); end
    n_checks++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %0b want 1", bus.imem_req); end
    n_checks++; if (bus.imem_addr !== 10'd0) begin n_fail++; $display("FAIL rmid_addr: got %0d want 0", bus.imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    bus.if_ready = 1'b1;
    @(negedge clk1);
    bus.br_taken = 1'b1;
    bus.br_target = 32'hFFFF_FFFF;
    @(negedge clk1);
    bus.br_taken = 1'b0;
    #2;
    n_checks++; if (bus.imem_addr !== 10'h3FF) begin n_fail++; $display("FAIL wrap_addr_top: got %h want 3ff", bus.imem_addr); end
    @(negedge clk1);
    #2;
    n_checks++; if (bus.imem_addr !== 10'h0) begin n_fail++; $display("FAIL wrap_addr_zero: got %h want 0", bus.imem_addr); end
    repeat (4) @(negedge clk1);
    #2;
    n_checks++; if (dl_ir[0] !== 32'hCAFE_03FF) begin n_fail++; $display("FAIL wrap_ir0: got %h want cafe03ff", dl_ir[0]); end
    n_checks++; if (dl_npc[0] !== 32'h0) begin n_fail++; $display("FAIL wrap_npc0: got %h want 0", dl_npc[0]); end
    n_checks++; if (dl_ir[1] !== 32'hCAFE_0000) begin n_fail++; $display("FAIL wrap_ir1: got %h want cafe0000", dl_ir[1]); end
    n_checks++; if (dl_npc[1] !== 32'h1) begin n_fail++; $display("FAIL wrap_npc1: got %h want 1", dl_npc[1]); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hCAFE_0000 + 32'(i);
    rst_n = 1'b0;
    bus.imem_gnt = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    bus.if_ready = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.halt = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_same_cycle();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
